regf_wb_arb: RTL and testbench

//  Shares the single register-file write port among NREQ writeback requesters
//  (ALU, load unit, debug, ...) using round-robin arbitration with valid/ready.

---
 rtl/regf_wb_arb.sv | 137 +++++++++++++
 tb/tb_regf_wb_arb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regf_wb_arb.sv
// regf_wb_arb -- register-file writeback arbiter with pending-write scoreboard.
//
// Purpose:
//   NREQ writeback requesters share the single regfile write port through a
//   round-robin arbiter with valid/ready handshakes. The accepted write is
//   registered and presented to the regfile one cycle later. A scoreboard of
//   pending writes over all architectural registers is set by issue
//   reservations and cleared when the matching write commits. Three query
//   ports report read-after-write hazards.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_req_valid/addr/data         requester k write request, slices k*AW / k*DW
//   o_req_ready                   one-hot grant
//   o_we, o_waddr, o_wdata        registered regfile write port
//   i_rsv_en, i_rsv_addr          destination reservation from issue
//   i_qaddr, o_qbusy              three hazard queries, slices q*AW
//   o_err                         sticky double-reservation error
module regf_wb_arb #(
    parameter int NREQ = 3,
    parameter int AW   = 6,
    parameter int DW   = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ*AW-1:0]   i_req_addr,
    input  logic [NREQ*DW-1:0]   i_req_data,
    output logic [NREQ-1:0]      o_req_ready,
    output logic                 o_we,
    output logic [AW-1:0]        o_waddr,
    output logic [DW-1:0]        o_wdata,
    input  logic                 i_rsv_en,
    input  logic [AW-1:0]        i_rsv_addr,
    input  logic [3*AW-1:0]      i_qaddr,
    output logic [2:0]           o_qbusy,
    output logic                 o_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NR = 2 ** AW;
    localparam logic [AW-1:0] PC_ADDR = AW'(NR - 1);

    logic [PW-1:0] ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [NR-1:0] pending_q, pending_d;
    logic          err_q, err_d;

    logic          grant_any;
    logic [PW-1:0] grant_idx;
    logic [AW-1:0] grant_addr;
    logic [DW-1:0] grant_data;
    logic          rsv_set;

    // $zero and $pc are read-only: never written, never tracked.
    function automatic logic writable(input logic [AW-1:0] a);
        return (a != '0) && (a != PC_ADDR);
    endfunction

    // Round-robin search starting at the pointer; no grant while in reset.
    always_comb begin
        int k;
        k          = 0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(ptr_q) + i) % NREQ;
            if (!i_rst && !grant_any && i_req_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = PW'(k);
            end
        end
        o_req_ready = grant_any ? (NREQ'(1) << grant_idx) : '0;
        grant_addr  = i_req_addr[int'(grant_idx)*AW +: AW];
        grant_data  = i_req_data[int'(grant_idx)*DW +: DW];
    end

    always_comb begin
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (grant_any) begin
            ptr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            if (writable(grant_addr)) begin
                we_d    = 1'b1;
                waddr_d = grant_addr;
                wdata_d = grant_data;
            end
        end
    end

    // Clear on commit first, then set, so a same-cycle reuse keeps the bit.
    always_comb begin
        rsv_set   = i_rsv_en && writable(i_rsv_addr);
        pending_d = pending_q;
        if (we_q)
            pending_d[waddr_q] = 1'b0;
        if (rsv_set)
            pending_d[i_rsv_addr] = 1'b1;
        pending_d[0]    = 1'b0;
        pending_d[NR-1] = 1'b0;
        err_d = err_q | (rsv_set && pending_q[i_rsv_addr]
                         && !(we_q && (waddr_q == i_rsv_addr)));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q     <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        for (int q = 0; q < 3; q++)
            o_qbusy[q] = pending_q[i_qaddr[q*AW +: AW]];
    end

    assign o_we    = we_q;
    assign o_waddr = waddr_q;
    assign o_wdata = wdata_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_regf_wb_arb.sv
module tb_regf_wb_arb;

    localparam int NREQ = 3;
    localparam int AW   = 6;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   rv;
    logic [AW-1:0]     ra [NREQ];
    logic [DW-1:0]     rd [NREQ];
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic [AW-1:0]     qa [3];
    logic [3*AW-1:0]   qaddr;
    logic [2:0]        qbusy;
    logic              err;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            req_addr[k*AW +: AW] = ra[k];
            req_data[k*DW +: DW] = rd[k];
        end
        for (int q = 0; q < 3; q++)
            qaddr[q*AW +: AW] = qa[q];
    end

    regf_wb_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(rv), .i_req_addr(req_addr), .i_req_data(req_data),
        .o_req_ready(req_ready),
        .o_we(we), .o_waddr(waddr), .o_wdata(wdata),
        .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr),
        .i_qaddr(qaddr), .o_qbusy(qbusy), .o_err(err)
    );

    // Reference model state.
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int due; } wr_t;
    wr_t  exq[$];
    int   m_ptr;
    logic m_pend [64];
    logic m_err;
    logic m_cur_we;
    logic [AW-1:0] m_cur_addr;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", n, cyc, act, exp);
        end
    endtask

    function automatic logic wr_ok(input logic [AW-1:0] a);
        return (a != 0) && (a != 63);
    endfunction

    // One clock cycle: check combinational outputs against the model at the
    // falling edge, advance the model, then release accepted requesters.
    task automatic step();
        int g;
        int k;
        logic nxt_we;
        logic [AW-1:0] nxt_addr;
        @(negedge clk);
        g = -1;
        if (!rst)
            for (int i = 0; i < NREQ; i++) begin
                k = (m_ptr + i) % NREQ;
                if (g < 0 && rv[k]) g = k;
            end
        if (chk_en) begin
            chk("ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
            for (int q = 0; q < 3; q++)
                chk("qbusy", 32'(qbusy[q]), 32'(m_pend[qa[q]]));
            chk("err", 32'(err), 32'(m_err));
        end
        nxt_we = 1'b0;
        nxt_addr = m_cur_addr;
        if (rst) begin
            m_ptr = 0;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_err = 1'b0;
            nxt_addr = '0;
        end else begin
            if (rsv_en && wr_ok(rsv_addr) && m_pend[rsv_addr]
                && !(m_cur_we && m_cur_addr == rsv_addr))
                m_err = 1'b1;
            if (m_cur_we) m_pend[m_cur_addr] = 1'b0;
            if (rsv_en && wr_ok(rsv_addr)) m_pend[rsv_addr] = 1'b1;
            if (g >= 0) begin
                m_ptr = (g + 1) % NREQ;
                if (wr_ok(ra[g])) begin
                    exq.push_back('{a: ra[g], d: rd[g], due: cyc + 1});
                    nxt_we = 1'b1;
                    nxt_addr = ra[g];
                end
            end
        end
        m_cur_we = nxt_we;
        m_cur_addr = nxt_addr;
        @(posedge clk);
        #1;
        if (g >= 0) rv[g] = 1'b0;
    endtask

    // Monitor: every regfile write must match the next expected write, in
    // the cycle it is due.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (exq.size() > 0 && exq[0].due == cyc) begin
                    chk("we", 32'(we), 32'd1);
                    chk("waddr", 32'(waddr), 32'(exq[0].a));
                    chk("wdata", wdata, exq[0].d);
                    void'(exq.pop_front());
                end else begin
                    chk("we_idle", 32'(we), 32'd0);
                    if (exq.size() > 0 && exq[0].due < cyc) begin
                        chk("stale_write", 32'(exq[0].due), 32'(cyc));
                        void'(exq.pop_front());
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        rsv_en = 1'b0;
        rsv_addr = '0;
        for (int q = 0; q < 3; q++) qa[q] = '0;
    endtask

    initial begin
        rst = 1'b1;
        rv = '0;
        for (int k = 0; k < NREQ; k++) begin ra[k] = '0; rd[k] = '0; end
        idle_inputs();
        m_ptr = 0; m_err = 1'b0; m_cur_we = 1'b0; m_cur_addr = '0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        @(posedge clk); #1;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;

        // 1: idle after reset
        step();
        chk("t1_we", 32'(we), 32'd0);
        chk("t1_err", 32'(err), 32'd0);

        // 2: three requesters at once, round-robin order 0,1,2
        for (int k = 0; k < NREQ; k++) begin
            rv[k] = 1'b1; ra[k] = AW'(5 + k); rd[k] = 32'hA000_0000 + 32'(k);
        end
        for (int k = 0; k < NREQ; k++) begin
            step();
            chk("t2_we", 32'(we), 32'd1);
            chk("t2_waddr", 32'(waddr), 32'(5 + k));
            chk("t2_wdata", wdata, 32'hA000_0000 + 32'(k));
        end
        step();

        // 3: reserve r9, hazard until its write commits
        rsv_en = 1'b1; rsv_addr = 6'd9;
        step();
        rsv_en = 1'b0; qa[0] = 6'd9;
        #1 chk("t3_busy", 32'(qbusy[0]), 32'd1);
        rv[0] = 1'b1; ra[0] = 6'd9; rd[0] = 32'hDEADBEEF;
        step();
        chk("t3_we", 32'(we), 32'd1);
        chk("t3_wdata", wdata, 32'hDEADBEEF);
        chk("t3_busy_n1", 32'(qbusy[0]), 32'd1);
        step();
        chk("t3_busy_n2", 32'(qbusy[0]), 32'd0);

        // 4: writes to $zero and $pc are accepted but suppressed
        rv[1] = 1'b1; ra[1] = 6'd0; rd[1] = 32'h1111;
        step();
        rv[1] = 1'b1; ra[1] = 6'd63; rd[1] = 32'h2222;
        step();
        chk("t4_we", 32'(we), 32'd0);
        step();
        chk("t4_we2", 32'(we), 32'd0);

        // 5a: double reservation raises sticky error
        rsv_en = 1'b1; rsv_addr = 6'd4;
        step();
        step();
        rsv_en = 1'b0;
        step();
        chk("t5_err", 32'(err), 32'd1);
        step();
        chk("t5_err_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        // 5b: reservation in the same cycle as the commit to r4
        rsv_en = 1'b1; rsv_addr = 6'd4;
        step();
        rsv_en = 1'b0;
        rv[0] = 1'b1; ra[0] = 6'd4; rd[0] = 32'h4444;
        step();
        rsv_en = 1'b1; rsv_addr = 6'd4; qa[1] = 6'd4;
        chk("t5_we_r4", 32'(we), 32'd1);
        step();
        rsv_en = 1'b0;
        #1 chk("t5_pend", 32'(qbusy[1]), 32'd1);
        chk("t5_no_err", 32'(err), 32'd0);

        // 6: reset while requests are pending, after an accept
        rv[1] = 1'b1; ra[1] = 6'd12; rd[1] = 32'h1212;
        step();
        for (int k = 0; k < NREQ; k++) begin
            rv[k] = 1'b1; ra[k] = AW'(20 + k); rd[k] = 32'(k);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t6_we", 32'(we), 32'd0);
        chk("t6_qbusy", 32'(qbusy), 32'd0);
        chk("t6_ptr0", 32'(req_ready), 32'd1);
        for (int n = 0; n < 4; n++) step();

        // Random phase: protocol-correct requesters, biased addresses.
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NREQ; k++)
                if (!rv[k] && $urandom_range(2) == 0) begin
                    rv[k] = 1'b1;
                    case ($urandom_range(9))
                        0: ra[k] = 6'd0;
                        1: ra[k] = 6'd63;
                        default: ra[k] = AW'($urandom_range(15));
                    endcase
                    rd[k] = $urandom;
                end
            rsv_en = ($urandom_range(3) == 0);
            rsv_addr = ($urandom_range(15) == 0) ? 6'd63 : AW'($urandom_range(15));
            for (int q = 0; q < 3; q++) qa[q] = AW'($urandom_range(15));
            rst = ($urandom_range(199) == 0);
            step();
        end
        rst = 1'b0;
        rv = '0;
        idle_inputs();
        for (int n = 0; n < 4; n++) step();
        chk("queue_drained", 32'(exq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
